// File: rtl/dcm_lock_supervisor.sv
// ============================================================================
// Module      : dcm_lock_supervisor
// Description : Reset/lock sequencer for one DCM_SP, clocked by the reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcm_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1000000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clkIn,
  input  logic       rstIn,
  input  logic       dcmLocked,
  input  logic [7:0] dcmStatus,
  output logic       dcmRst,
  output logic       dcmReady,
  output logic       fail,
  output logic [7:0] retryCnt,
  output logic [7:0] unlockCnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       c_max_retry    = 8'(MAX_RETRY);

  logic [1:0]       lock_sync_q, stat1_sync_q, stat2_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic [7:0]       unlock_q, unlock_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             w_good;
  logic             w_attempt_fail;
  logic             w_unused_status;

  assign w_good = lock_sync_q[1] & ~stat1_sync_q[1] & ~stat2_sync_q[1];
  assign w_unused_status = ^{dcmStatus[7:3], dcmStatus[0]};

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      lock_sync_q  <= '0;
      stat1_sync_q <= '0;
      stat2_sync_q <= '0;
      state_q      <= S_RESET;
      cnt_q        <= '0;
      retry_q      <= '0;
      unlock_q     <= '0;
      dcm_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      lock_sync_q  <= {lock_sync_q[0], dcmLocked};
      stat1_sync_q <= {stat1_sync_q[0], dcmStatus[1]};
      stat2_sync_q <= {stat2_sync_q[0], dcmStatus[2]};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      unlock_q     <= unlock_d;
      dcm_rst_q    <= dcm_rst_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    unlock_d       = unlock_q;
    w_attempt_fail = 1'b0;

    case (state_q)
      S_RESET: begin
        if (cnt_q == c_rst_last) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        // A lock seen on the timeout cycle still wins.
        if (w_good) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == c_timeout_last) begin
          w_attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (!w_good) begin
          w_attempt_fail = 1'b1;
        end else if (cnt_q == c_settle_last) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!w_good) begin
          state_d = S_RESET;
          cnt_d   = '0;
          if (unlock_q != 8'hFF) unlock_d = unlock_q + 8'(1);
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase

    if (w_attempt_fail) begin
      if (retry_q == c_max_retry) begin
        state_d = S_FAIL;
      end else begin
        state_d = S_RESET;
        cnt_d   = '0;
        if (retry_q != 8'hFF) retry_d = retry_q + 8'(1);
      end
    end

    // Outputs are registered from the next state so they track the state register.
    dcm_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  assign dcmRst    = dcm_rst_q;
  assign dcmReady  = ready_q;
  assign fail      = fail_q;
  assign retryCnt  = retry_q;
  assign unlockCnt = unlock_q;
  assign state     = state_q;

endmodule

`default_nettype wire
